// File: rtl/stream_minmax_if.sv
// stream_minmax_if: sample-in / result-out valid-ready bundle for stream_minmax.
interface stream_minmax_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_min;
  logic [DATA_WIDTH-1:0]  out_max;
  logic [COUNT_WIDTH-1:0] out_count;
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );
endinterface

// File: rtl/stream_minmax.sv
// stream_minmax: per-frame min/max/saturating count over a valid/ready sample stream.
module stream_minmax #(
  parameter int DATA_WIDTH  = 8,
  parameter bit IS_SIGNED   = 1'b0,
  parameter int COUNT_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  stream_minmax_if.slave  bus_io
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t                 state_q, state_d;
  logic                   first_q, first_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  min_q, min_d, max_q, max_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   accept, fire;
  // Signed ordering: differing MSBs decide directly, otherwise unsigned compare.
  function automatic logic lt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (IS_SIGNED && (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])) ? a[DATA_WIDTH-1] : (a < b);
  endfunction
  assign bus_io.in_ready  = (state_q == ACC) & ~rst;
  assign bus_io.out_valid = valid_q;
  assign bus_io.out_min   = min_q;
  assign bus_io.out_max   = max_q;
  assign bus_io.out_count = cnt_q;
  assign accept = bus_io.in_valid & bus_io.in_ready;
  assign fire   = valid_q & bus_io.out_ready;
  always_comb begin
    min_d   = accept && (first_q || lt(bus_io.in_data, min_q)) ? bus_io.in_data : min_q;
    max_d   = accept && (first_q || lt(max_q, bus_io.in_data)) ? bus_io.in_data : max_q;
    cnt_d   = !accept ? cnt_q : first_q ? COUNT_WIDTH'(1) : (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    first_d = accept ? bus_io.in_last : first_q;
    state_d = (accept && bus_io.in_last) ? HOLD : fire ? ACC : state_q;
    valid_d = (state_d == HOLD);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      valid_q <= valid_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_minmax.sv
// tb_stream_minmax: drives one stream into an unsigned/16-bit-count and a signed/4-bit-count instance.
module tb_stream_minmax;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [7:0] umin, umax, smin, smax;
    int         cnt;
  } res_t;
  res_t       sb[$];
  res_t       acc;
  logic       m_first = 1'b1;
  stream_minmax_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) u_if ();
  stream_minmax_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4))  s_if ();
  assign u_if.in_valid  = in_valid;
  assign u_if.in_data   = in_data;
  assign u_if.in_last   = in_last;
  assign u_if.out_ready = out_ready;
  assign s_if.in_valid  = in_valid;
  assign s_if.in_data   = in_data;
  assign s_if.in_last   = in_last;
  assign s_if.out_ready = out_ready;
  stream_minmax #(.DATA_WIDTH(8), .IS_SIGNED(1'b0), .COUNT_WIDTH(16)) dut_u (.clk(clk), .rst(rst), .bus_io(u_if));
  stream_minmax #(.DATA_WIDTH(8), .IS_SIGNED(1'b1), .COUNT_WIDTH(4))  dut_s (.clk(clk), .rst(rst), .bus_io(s_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Reference fold: signed ordering via $signed, independent of the DUT's MSB rule.
  task automatic fold(input logic [7:0] d, input logic l);
    if (m_first) begin
      acc.umin = d; acc.umax = d; acc.smin = d; acc.smax = d; acc.cnt = 1;
    end else begin
      if (d < acc.umin) acc.umin = d;
      if (d > acc.umax) acc.umax = d;
      if ($signed(d) < $signed(acc.smin)) acc.smin = d;
      if ($signed(d) > $signed(acc.smax)) acc.smax = d;
      acc.cnt++;
    end
    m_first = l;
    if (l) sb.push_back(acc);
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!u_if.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_wait", u_if.in_ready, 1);
    chk("in_ready_match", s_if.in_ready, u_if.in_ready);
    step();
    fold(d, l);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && u_if.out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_valid", u_if.out_valid, 0);
      else begin
        res_t r;
        r = sb.pop_front();
        chk("u_min", u_if.out_min, r.umin);
        chk("u_max", u_if.out_max, r.umax);
        chk("u_count", u_if.out_count, r.cnt);
        chk("s_valid", s_if.out_valid, 1);
        chk("s_min", s_if.out_min, r.smin);
        chk("s_max", s_if.out_max, r.smax);
        chk("s_count", s_if.out_count, (r.cnt > 15) ? 15 : r.cnt);
      end
    end
  end
  initial begin
    int n;
    #2;
    chk("rst_in_ready", u_if.in_ready, 0);
    chk("rst_out_valid", u_if.out_valid, 0);
    chk("rst_out_count", u_if.out_count, 0);
    chk("rst_s_in_ready", s_if.in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", u_if.in_ready, 1);
    step();
    send(8'h10, 0); send(8'h05, 0); send(8'hF0, 0);
    chk("valid_before_last", u_if.out_valid, 0);
    send(8'h20, 1);
    chk("latency_valid", u_if.out_valid, 1);
    chk("hold_in_ready", u_if.in_ready, 0);
    step();
    chk("valid_cleared", u_if.out_valid, 0);
    chk("acc_in_ready", u_if.in_ready, 1);
    send(8'h7F, 0); send(8'h80, 0); send(8'hFF, 0); send(8'h00, 1);
    step();
    out_ready = 1'b0;
    send(8'h30, 0); send(8'hA0, 0); send(8'h50, 1);
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", u_if.in_ready, 0);
      chk("bp_out_valid", u_if.out_valid, 1);
      chk("bp_min", u_if.out_min, 8'h30);
      chk("bp_max", u_if.out_max, 8'hA0);
      chk("bp_count", u_if.out_count, 3);
    end
    out_ready = 1'b1;
    send(8'h77, 0);
    send(8'h66, 1);
    step();
    send(8'h33, 1);
    step();
    send(8'h40, 0); send(8'h40, 0); send(8'h40, 1);
    step();
    for (int i = 0; i < 20; i++) send(8'((i * 37 + 11) & 8'hFF), i == 19);
    step();
    send(8'h01, 0); send(8'h02, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", u_if.in_ready, 0);
    chk("mid_rst_min", u_if.out_min, 0);
    chk("mid_rst_max", u_if.out_max, 0);
    chk("mid_rst_count", u_if.out_count, 0);
    chk("mid_rst_s_min", s_if.out_min, 0);
    step();
    rst = 1'b0;
    m_first = 1'b1;
    #1;
    send(8'h09, 0); send(8'h08, 1);
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
